// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic [DW-1:0] imm_i,
    input  logic [AW-1:0] rs_addr_i,
    input  logic [AW-1:0] rt_addr_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          uses_rt_i,
    input  logic [CW-1:0] alu_ctrl_i,
    input  logic [4:0]    shamt_i,
    input  logic          alu_src_i,
    input  logic          reg_write_i,
    input  logic          mem_read_i,
    input  logic          mem_write_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          exmem_reg_write_i,
    input  logic [AW-1:0] exmem_rd_i,
    input  logic [DW-1:0] exmem_result_i,
    input  logic          memwb_reg_write_i,
    input  logic [AW-1:0] memwb_rd_i,
    input  logic [DW-1:0] memwb_result_i,
    output logic [DW-1:0] src1_o,
    output logic [DW-1:0] src2_o,
    output logic [CW-1:0] ctrl_o,
    output logic [4:0]    shamt_o,
    output logic [DW-1:0] store_data_o,
    output logic [AW-1:0] rd_o,
    output logic          reg_write_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic          valid_o,
    output logic          stall_req_o
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [AW-1:0] rs_addr;
        logic [AW-1:0] rt_addr;
        logic [AW-1:0] rd;
        logic [CW-1:0] alu_ctrl;
        logic [4:0]    shamt;
        logic          alu_src;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    // Reset is handled in the flop; flush clears like reset, stall holds.
    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = '0;
        end else if (!stall_i) begin
            stage_d.valid     = valid_i;
            stage_d.rs_data   = rs_data_i;
            stage_d.rt_data   = rt_data_i;
            stage_d.imm       = imm_i;
            stage_d.rs_addr   = rs_addr_i;
            stage_d.rt_addr   = rt_addr_i;
            stage_d.rd        = rd_addr_i;
            stage_d.alu_ctrl  = alu_ctrl_i;
            stage_d.shamt     = shamt_i;
            stage_d.alu_src   = alu_src_i;
            stage_d.reg_write = reg_write_i;
            stage_d.mem_read  = mem_read_i;
            stage_d.mem_write = mem_write_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    logic exmem_hit_rs;
    logic memwb_hit_rs;
    logic exmem_hit_rt;
    logic memwb_hit_rt;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // EX/MEM is the younger producer so it wins; r0 is hardwired and never forwarded.
    always_comb begin
        exmem_hit_rs = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rs_addr);
        memwb_hit_rs = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rs_addr);
        exmem_hit_rt = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rt_addr);
        memwb_hit_rt = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rt_addr);

        if (exmem_hit_rs)      fwd_rs = exmem_result_i;
        else if (memwb_hit_rs) fwd_rs = memwb_result_i;
        else                   fwd_rs = stage_q.rs_data;

        if (exmem_hit_rt)      fwd_rt = exmem_result_i;
        else if (memwb_hit_rt) fwd_rt = memwb_result_i;
        else                   fwd_rt = stage_q.rt_data;
    end

    always_comb begin
        src1_o       = fwd_rs;
        store_data_o = fwd_rt;
        src2_o       = stage_q.alu_src ? stage_q.imm : fwd_rt;
        ctrl_o       = stage_q.alu_ctrl;
        shamt_o      = stage_q.shamt;
        rd_o         = stage_q.rd;
        valid_o      = stage_q.valid;
        reg_write_o  = stage_q.reg_write & stage_q.valid;
        mem_read_o   = stage_q.mem_read & stage_q.valid;
        mem_write_o  = stage_q.mem_write & stage_q.valid;
    end

    // A load here cannot forward its data in time to a dependent instruction in decode.
    always_comb begin
        stall_req_o = stage_q.valid && stage_q.mem_read && (stage_q.rd != '0) && valid_i &&
                      ((stage_q.rd == rs_addr_i) || (uses_rt_i && (stage_q.rd == rt_addr_i)));
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] rs_data_i, rt_data_i, imm_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
    logic        uses_rt_i;
    logic [3:0]  alu_ctrl_i;
    logic [4:0]  shamt_i;
    logic        alu_src_i, reg_write_i, mem_read_i, mem_write_i;
    logic        stall_i, flush_i;
    logic        exmem_reg_write_i;
    logic [4:0]  exmem_rd_i;
    logic [31:0] exmem_result_i;
    logic        memwb_reg_write_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_result_i;
    logic [31:0] src1_o, src2_o, store_data_o;
    logic [3:0]  ctrl_o;
    logic [4:0]  shamt_o, rd_o;
    logic        reg_write_o, mem_read_o, mem_write_o, valid_o, stall_req_o;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .uses_rt_i(uses_rt_i), .alu_ctrl_i(alu_ctrl_i), .shamt_i(shamt_i),
        .alu_src_i(alu_src_i), .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .stall_i(stall_i), .flush_i(flush_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
        .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
        .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o), .shamt_o(shamt_o),
        .store_data_o(store_data_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .valid_o(valid_o),
        .stall_req_o(stall_req_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic decode(input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                          input logic [4:0] rs_a, input logic [4:0] rt_a, input logic [4:0] rd_a,
                          input logic [3:0] ctrl, input logic [4:0] sh, input logic src,
                          input logic rw, input logic mr, input logic mw);
        valid_i = 1'b1;
        rs_data_i = rs_d; rt_data_i = rt_d; imm_i = imm;
        rs_addr_i = rs_a; rt_addr_i = rt_a; rd_addr_i = rd_a;
        alu_ctrl_i = ctrl; shamt_i = sh; alu_src_i = src;
        reg_write_i = rw; mem_read_i = mr; mem_write_i = mw;
    endtask

    task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                       input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_reg_write_i = ew; exmem_rd_i = erd; exmem_result_i = eres;
        memwb_reg_write_i = mw; memwb_rd_i = mrd; memwb_result_i = mres;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; uses_rt_i = 1'b1;
        decode(32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_00FF, 5'd3, 5'd4, 5'd5,
               4'd7, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        fwd(1'b0, 5'd3, 32'h5555_5555, 1'b0, 5'd4, 32'h6666_6666);
        tick();
        tick();
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_reg_write", {31'd0, reg_write_o}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read_o}, 32'd0);
        check("rst_src1", src1_o, 32'd0);
        check("rst_src2", src2_o, 32'd0);
        check("rst_ctrl", {28'd0, ctrl_o}, 32'd0);
        check("rst_rd", {27'd0, rd_o}, 32'd0);
        check("rst_stall_req", {31'd0, stall_req_o}, 32'd0);
        rst_i = 1'b0;

        decode(32'h5, 32'h3, 32'h0, 5'd1, 5'd2, 5'd3, 4'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("load_src1", src1_o, 32'h5);
        check("load_src2", src2_o, 32'h3);
        check("load_ctrl", {28'd0, ctrl_o}, 32'd2);
        check("load_valid", {31'd0, valid_o}, 32'd1);
        check("load_reg_write", {31'd0, reg_write_o}, 32'd1);

        decode(32'hAA, 32'hBB, 32'h0, 5'd8, 5'd2, 5'd3, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        fwd(1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22);
        check("fwd_exmem_prio", src1_o, 32'h11);
        fwd(1'b0, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22);
        check("fwd_memwb", src1_o, 32'h22);
        fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        check("fwd_r0_blocked", src1_o, 32'hAA);
        fwd(1'b1, 5'd7, 32'h11, 1'b1, 5'd6, 32'h22);
        check("fwd_no_match", src1_o, 32'hAA);

        decode(32'h1, 32'h5, 32'hFFFF_FFFC, 5'd1, 5'd4, 5'd3, 4'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h77);
        tick();
        check("imm_src2", src2_o, 32'hFFFF_FFFC);
        check("imm_store_data", store_data_o, 32'h77);
        check("imm_src1", src1_o, 32'h1);

        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        decode(32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd9, 4'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("lw_mem_read", {31'd0, mem_read_o}, 32'd1);
        rs_addr_i = 5'd9; rt_addr_i = 5'd0; uses_rt_i = 1'b1; #1;
        check("lu_rs", {31'd0, stall_req_o}, 32'd1);
        rs_addr_i = 5'd1; rt_addr_i = 5'd9; uses_rt_i = 1'b0; #1;
        check("lu_rt_unused", {31'd0, stall_req_o}, 32'd0);
        uses_rt_i = 1'b1; #1;
        check("lu_rt_used", {31'd0, stall_req_o}, 32'd1);
        valid_i = 1'b0; #1;
        check("lu_decode_invalid", {31'd0, stall_req_o}, 32'd0);
        decode(32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 4'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        rs_addr_i = 5'd0; rt_addr_i = 5'd0; uses_rt_i = 1'b1; #1;
        check("lu_rd_zero", {31'd0, stall_req_o}, 32'd0);

        decode(32'h100, 32'h200, 32'h0, 5'd10, 5'd11, 5'd6, 4'd5, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            decode(32'h900 + i, 32'hA00 + i, 32'hB00 + i, 5'd20, 5'd21, 5'd22,
                   4'(i + 9), 5'(i + 1), 1'b1, 1'b0, 1'b1, 1'b0);
            valid_i = i[0];
            tick();
            check("stall_src1", src1_o, 32'h100);
            check("stall_src2", src2_o, 32'h200);
            check("stall_ctrl_shamt_rd", {19'd0, ctrl_o, shamt_o, rd_o}, {19'd0, 4'd5, 5'd7, 5'd6});
            check("stall_flags", {28'd0, valid_o, reg_write_o, mem_read_o, mem_write_o}, 32'b1101);
        end
        fwd(1'b1, 5'd10, 32'h333, 1'b0, 5'd0, 32'h0);
        check("stall_fwd_src1", src1_o, 32'h333);
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        flush_i = 1'b1;
        decode(32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'd4, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("flush_flags", {28'd0, valid_o, reg_write_o, mem_read_o, mem_write_o}, 32'd0);
        check("flush_ctrl_rd", {23'd0, ctrl_o, rd_o}, 32'd0);
        check("flush_src1", src1_o, 32'd0);
        flush_i = 1'b0; stall_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that feeds the ALU with src1, src2, ctrl, and shamt.
- Captures decoded operands and control from the decode stage.
- Applies EX/MEM and MEM/WB operand forwarding on its outputs.
- Detects load-use hazards and supports stall and flush, so the ALU never sees stale register data.

Parameters:
- DW, 32, datapath width (operands, immediate, forwarded results).
- AW, 5, register address width.
- CW, 4, ALU control width (ALU opcodes 0..12).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  decode stage presents a real instruction.
- rs_data_i  in  DW  register-file read data for rs.
- rt_data_i  in  DW  register-file read data for rt.
- imm_i  in  DW  extended immediate (sign- or zero-extended by the decoder).
- rs_addr_i  in  AW  rs index.
- rt_addr_i  in  AW  rt index.
- rd_addr_i  in  AW  destination index (already muxed rt/rd by the decoder).
- uses_rt_i  in  1  instruction reads rt as a register operand.
- alu_ctrl_i  in  CW  ALU operation.
- shamt_i  in  5  shift amount field.
- alu_src_i  in  1  1 selects imm as src2.
- reg_write_i  in  1  instruction writes rd.
- mem_read_i  in  1  instruction is a load.
- mem_write_i  in  1  instruction is a store.
- stall_i  in  1  hold stage contents.
- flush_i  in  1  replace stage contents with a bubble.
- exmem_reg_write_i  in  1  EX/MEM instruction writes a register.
- exmem_rd_i  in  AW  EX/MEM destination.
- exmem_result_i  in  DW  EX/MEM ALU result.
- memwb_reg_write_i  in  1  MEM/WB instruction writes a register.
- memwb_rd_i  in  AW  MEM/WB destination.
- memwb_result_i  in  DW  MEM/WB writeback value.
- src1_o  out  DW  ALU operand 1 (forwarded rs).
- src2_o  out  DW  ALU operand 2 (imm or forwarded rt).
- ctrl_o  out  CW  ALU control.
- shamt_o  out  5  ALU shift amount.
- store_data_o  out  DW  forwarded rt, for stores.
- rd_o  out  AW  destination index.
- reg_write_o  out  1  gated with valid.
- mem_read_o  out  1  gated with valid.
- mem_write_o  out  1  gated with valid.
- valid_o  out  1  stage holds a real instruction.
- stall_req_o  out  1  load-use hazard; decode/fetch must stall.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Update priority per rising edge: rst_i > flush_i > stall_i > load.
- Reset: every stored field is cleared to 0.
  - Resulting outputs: valid_o=0, reg_write_o=0, mem_read_o=0, mem_write_o=0, ctrl_o=0, shamt_o=0, rd_o=0, stall_req_o=0.
  - With both forwarding write-enables low, src1_o=0 and src2_o=0.
- Flush: all stored fields are cleared to 0, same as reset. Flush wins over a simultaneous stall.
- Stall (without flush): all stored fields hold, and inputs are ignored.
- Load (otherwise): all *_i decode fields are registered.
- Latency: 1 cycle from decode inputs to stage outputs.
- Forwarding is combinational from the registered fields and the current-cycle forwarding inputs:
  - fwd(a, d) = exmem_result_i if exmem_reg_write_i and exmem_rd_i!=0 and exmem_rd_i==a.
  - Otherwise memwb_result_i if memwb_reg_write_i and memwb_rd_i!=0 and memwb_rd_i==a.
  - Otherwise the stored data d.
  - EX/MEM has priority over MEM/WB when both match. Register 0 is never forwarded.
- Output mapping:
  - src1_o = fwd(rs_q, rs_data_q).
  - store_data_o = fwd(rt_q, rt_data_q).
  - src2_o = alu_src_q ? imm_q : store_data_o.
- Forwarding also applies during stall, so held operands pick up newly arriving results.
- reg_write_o, mem_read_o, and mem_write_o are each ANDed with valid_q.
- ctrl_o, shamt_o, and rd_o are driven from the registers regardless of valid.
- stall_req_o (combinational) = valid_q & mem_read_q & (rd_q!=0) & valid_i & ((rd_q==rs_addr_i) | (uses_rt_i & (rd_q==rt_addr_i))).
- Stall handshake:
  - The control unit responds to stall_req_o by asserting flush_i to this stage (bubble insertion) and holding fetch/decode.
  - This block does not self-flush.
- Arithmetic: no arithmetic inside the block; all widths pass through unchanged.

Test Plan:
- Reset: assert rst_i for 2 cycles with nonzero inputs, valid_i=1 → the cycle after, valid_o=0, reg_write_o=0, src1_o=0, src2_o=0, ctrl_o=0.
- Plain load: rs_data_i=0x00000005, rt_data_i=0x00000003, alu_ctrl_i=2, alu_src_i=0, valid_i=1 → next cycle src1_o=5, src2_o=3, ctrl_o=2, valid_o=1.
- Double forwarding:
  - Stage holds rs=8.
  - exmem (rd=8, result=0x11) and memwb (rd=8, result=0x22) both write → src1_o=0x11.
  - Drop exmem_reg_write_i → src1_o=0x22.
  - Set both rd to 0 → src1_o keeps the stored rs data.
- Immediate path: alu_src_i=1, imm_i=0xFFFFFFFC, rt forwarded to 0x77 → src2_o=0xFFFFFFFC, store_data_o=0x77.
- Load-use: stage holds a valid lw with rd=9; decode presents rs_addr_i=9 → stall_req_o=1.
  - Repeat with rt_addr_i=9, uses_rt_i=0 → stall_req_o=0.
  - Repeat with rd_q=0 → stall_req_o=0.
- Stall vs flush:
  - stall_i=1 for 3 cycles with changing inputs → outputs unchanged.
  - stall_i=1 and flush_i=1 together → next cycle valid_o=0, reg_write_o=0, mem_write_o=0.
